// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: select and state encodings shared by the UART transmit controller and shift register
package uart_tx_pkg;
  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_SHIFT = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10
  } state_e;
endpackage

// File: rtl/uart_tx_rr_arb2.sv
// uart_tx_rr_arb2: combinational two-way round-robin arbiter
module uart_tx_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);
  always_comb begin
    grant_idx = (valid == 2'b11) ? ~last_grant : valid[1];
    grant     = (enable && |valid) ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer and round-robin byte acceptor driving the UART transmit shift register
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 tx_en_i,
  input  logic [1:0]           req_valid_i,
  input  logic [WORD_SIZE-1:0] req_data0_i,
  input  logic [WORD_SIZE-1:0] req_data1_i,
  output logic [1:0]           req_ready_o,
  output logic [1:0]           tx_sel_o,
  output logic [WORD_SIZE-1:0] tx_data_o,
  output logic                 busy_o,
  output logic                 last_shift_o,
  output logic                 grant_id_o
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 last_bit, window, grant_idx, granted;
  logic [1:0]           grant;

  // The final SHIFT cycle doubles as the accept slot so frames run gapless
  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == CNT_W'(WORD_SIZE));
  assign window   = tx_en_i && ((state_q == ST_IDLE) || last_bit);
  assign granted  = |grant;

  uart_tx_rr_arb2 u_arb (
    .valid      (req_valid_i),
    .last_grant (last_grant_q),
    .enable     (window),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    state_d      = (state_q == ST_LOAD || (state_q == ST_SHIFT && !last_bit)) ? ST_SHIFT :
                   granted ? ST_LOAD : ST_IDLE;
    bit_cnt_d    = (state_q == ST_SHIFT && !last_bit) ? bit_cnt_q + CNT_W'(1) : '0;
    tx_data_d    = granted ? (grant_idx ? req_data1_i : req_data0_i) : tx_data_q;
    grant_id_d   = granted ? grant_idx : grant_id_q;
    last_grant_d = granted ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      tx_data_q    <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Any state outside LOAD/SHIFT, including the unused encoding, selects CLEAR
  always_comb begin
    tx_sel_o     = (state_q == ST_SHIFT) ? SEL_SHIFT : (state_q == ST_LOAD) ? SEL_LOAD : SEL_CLEAR;
    busy_o       = (state_q == ST_SHIFT) || (state_q == ST_LOAD);
    last_shift_o = last_bit;
    req_ready_o  = grant;
    tx_data_o    = tx_data_q;
    grant_id_o   = grant_id_q;
  end
endmodule
